// File: rtl/id_inst_queue_pkg.sv
// Shared definitions for the instruction queue between fetch and decode.
// Holds the decode NOP encoding and the default-width queue entry layout.
package id_inst_queue_pkg;

   localparam int          INST_W     = 32;
   localparam int          DEF_XLEN   = 32;
   localparam logic [31:0] BUBBLE_NOP = 32'h0000_0000;

   // Instruction/PC pair as stored in the queue at the default PC width.
   typedef struct packed {
      logic [INST_W-1:0]   inst;
      logic [DEF_XLEN-1:0] pc;
   } entry_t;

endpackage

// File: rtl/id_queue_fifo.sv
// Generic synchronous FIFO with separate occupancy counter and a clear input
// that empties it in one cycle. Callers must not push when full or pop when empty.
module id_queue_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; its content is only visible through a valid head.
   always_ff @(posedge clk) begin
      if (push && !rst && !clear) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between Icache fetch and decode: buffers inst/PC pairs,
// flushes on taken jumps and blocks fetch for a squash window afterwards.
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int          XLEN          = 32,
   parameter int          DEPTH         = 4,
   parameter int          SQUASH_CYCLES = 1,
   parameter logic [31:0] BUBBLE        = BUBBLE_NOP
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid_i,
   input  logic [31:0]            in_inst_i,
   input  logic [XLEN-1:0]        in_pc_i,
   output logic                   in_ready_o,
   output logic                   out_valid_o,
   output logic [31:0]            out_inst_o,
   output logic [XLEN-1:0]        out_pc_o,
   input  logic                   out_ready_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   squash_o
);

   localparam int SQ_W = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [XLEN-1:0]   pc;
   } q_entry_t;

   q_entry_t        wr_entry;
   q_entry_t        head;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic [SQ_W-1:0] squash_cnt;

   // A flush cycle discards everything, including a fetch or consume in that cycle.
   assign push = in_valid_i && in_ready_o && !flush_i;
   assign pop  = out_valid_o && out_ready_i && !flush_i;

   assign wr_entry.inst = in_inst_i;
   assign wr_entry.pc   = in_pc_i;

   id_queue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(q_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush_i),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .count (count_o),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         squash_cnt <= '0;
      end else if (flush_i) begin
         squash_cnt <= SQ_W'(SQUASH_CYCLES);
      end else if (squash_cnt != '0) begin
         squash_cnt <= squash_cnt - 1'b1;
      end
   end

   assign squash_o    = (squash_cnt != '0);
   assign in_ready_o  = !full && !squash_o;
   assign out_valid_o = !empty;
   assign out_inst_o  = empty ? BUBBLE : head.inst;
   assign out_pc_o    = empty ? '0 : head.pc;

endmodule

// File: doc/id_inst_queue.md
# id_inst_queue

Parametrised instruction queue between Icache fetch and the decode stage. It buffers fetched instruction/PC pairs in a DEPTH-entry FIFO. It holds the head stable under back-end (Dcache) stall and flushes all buffered entries on a taken jump. After a flush it blocks incoming fetch data for a programmable number of squash cycles. Decode always sees either a valid instruction or the BUBBLE encoding, never stale data.

## Interface
Parameters:
- XLEN, 32, PC width
- DEPTH, 4, FIFO entries; power of two, ≥2
- SQUASH_CYCLES, 1, cycles fetch input is blocked after flush_i; 0 disables squash
- BUBBLE, 32'h0000_0000, instruction presented when queue empty

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid_i  in  1  Icache data valid
- in_inst_i  in  32  fetched instruction
- in_pc_i  in  XLEN  PC of fetched instruction
- in_ready_o  out  1  queue accepts this cycle
- out_valid_o  out  1  head entry valid
- out_inst_o  out  32  head instruction, BUBBLE when empty
- out_pc_o  out  XLEN  head PC, 0 when empty
- out_ready_i  in  1  decode consumes head; low = Dcache stall
- flush_i  in  1  taken jump/branch; discard queue contents
- count_o  out  $clog2(DEPTH)+1  occupied entries
- squash_o  out  1  squash window active

## Operation
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = !full & (squash_cnt == 0). It has no combinational dependency on out_ready_i.
- out_valid_o = (count != 0). out_inst_o/out_pc_o come combinationally from the head storage entry, or BUBBLE/0 when empty.
- While out_valid_o & !out_ready_i, the head stays stable cycle to cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately. full = (count == DEPTH).
- flush_i has highest priority:
  - next cycle rd_ptr = wr_ptr = 0, count = 0, squash_cnt = SQUASH_CYCLES.
  - A push or pop in the flush cycle is ignored.
  - A fetch arriving with flush_i is dropped.
- Squash: while squash_cnt ≠ 0, in_ready_o = 0 and squash_cnt decrements by 1 per cycle. Data presented during this window is dropped; the Icache does not retry.
- flush_i during an active squash reloads squash_cnt to SQUASH_CYCLES.
- squash_o = (squash_cnt ≠ 0).
- Reset values: count_o = 0, out_valid_o = 0, out_inst_o = BUBBLE, out_pc_o = 0, in_ready_o = 1, squash_o = 0. Storage contents are don't-care but are never observable.
- Reset mid-operation behaves identically to flush with SQUASH_CYCLES = 0.

## Timing
- Latency: an entry pushed in cycle t appears on out_* in cycle t+1 if the queue was empty.
- Full: in_ready_o falls the cycle after the DEPTH-th push. It rises the cycle after the first pop.
- Flush at cycle t: out_valid_o = 0 from t+1. in_ready_o = 0 for cycles t+1 … t+SQUASH_CYCLES and returns to 1 at t+SQUASH_CYCLES+1. With SQUASH_CYCLES = 0, in_ready_o = 1 at t+1.
- No combinational path from in_valid_i to any output. Paths from out_ready_i and flush_i to outputs are register-only.

## Structure
- Shared package: BUBBLE default constant (matches the decode NOP encoding), and the inst/pc entry struct (inst[31:0], pc[XLEN-1:0]).
- One sub-module, id_queue_fifo: generic synchronous FIFO (DEPTH, WIDTH) with push/pop/clear/count.
- The top contains the squash counter, handshake logic and BUBBLE muxing.

## Test plan
- Reset, then idle: out_valid_o = 0, out_inst_o = 32'h0, in_ready_o = 1, count_o = 0 for 5 cycles.
- Push 4 entries (PC 0x0, 0x4, 0x8, 0xC) with out_ready_i = 0, DEPTH = 4: count_o = 4 and in_ready_o = 0 at cycle 5. Head holds PC 0x0 throughout the stall. Raise out_ready_i: entries drain in order 0x0, 0x4, 0x8, 0xC over 4 cycles.
- Continuous push+pop at steady state with count = 2: count_o stays 2 for 20 cycles. Output PC sequence is strictly +4, including across pointer wrap.
- Flush with 3 entries queued and in_valid_i = 1, SQUASH_CYCLES = 2: next cycle count_o = 0 and out_inst_o = BUBBLE. in_ready_o = 0 for 2 cycles, then 1. Data presented during squash never appears.
- flush_i pulsed again 1 cycle into the squash window: in_ready_o stays 0 for 2 cycles after the second flush.
- rst asserted with 2 entries queued and squash active: next cycle all outputs hold reset values and in_ready_o = 1.
